// File: rtl/pc_gen_unit_pkg.sv
// pc_gen_unit_pkg: fetch FSM state encoding and the fixed instruction step.
package pc_gen_unit_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  localparam int unsigned STEP = 4;
endpackage

// File: rtl/pc_ras_stack.sv
// pc_ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_sp, w_top_idx;
  logic [PW:0]     r_cnt;
  logic            w_pop;
  assign w_top_idx = r_sp - 1'b1;
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_cnt == '0);
  assign underflow = pop & empty;
  assign w_pop     = pop & ~empty;
  // Push together with a pop replaces the top in place instead of moving the pointer.
  always_ff @(posedge clk)
    if (push) r_mem[w_pop ? w_top_idx : r_sp] <= push_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (push & ~w_pop) begin
      r_sp  <= r_sp + 1'b1;
      r_cnt <= (r_cnt == FULL) ? r_cnt : r_cnt + 1'b1;
    end else if (w_pop & ~push) begin
      r_sp  <= r_sp - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch PC generator with trap/redirect/return-stack steering and BOOT/RUN/HALT control.
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4,
  parameter bit              C_EXT     = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  input  logic            halt_req,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic            misalign_err,
  output logic            ras_underflow,
  output logic            ras_empty
);
  state_t          r_state;
  logic [XLEN-1:0] r_pc, w_top, w_next;
  logic            r_fv, r_mis, r_unf, w_empty, w_unf, w_act, w_mis, w_pop, w_push;
  assign w_act  = (r_state == RUN) & ~trap_valid & ~stall & ~halt_req;
  assign w_mis  = C_EXT ? redirect_addr[0] : |redirect_addr[1:0];
  assign w_pop  = w_act & ~redirect_valid & ras_pop;
  assign w_push = ras_push & ~stall;
  assign w_next = r_pc + XLEN'(STEP);
  pc_ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_addr (ras_push_addr),
    .pop       (w_pop),
    .top       (w_top),
    .empty     (w_empty),
    .underflow (w_unf)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_VEC;
      r_fv    <= 1'b0;
      r_mis   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_mis <= w_act & redirect_valid & w_mis;
      r_unf <= w_unf;
      if (trap_valid) begin
        r_pc    <= trap_vec;
        r_state <= RUN;
        r_fv    <= 1'b1;
      end else if (r_state == BOOT) begin
        r_state <= RUN;
        r_fv    <= 1'b1;
      end else if (r_state == RUN && !stall) begin
        if (halt_req) begin
          r_state <= HALT;
          r_fv    <= 1'b0;
        end else if (redirect_valid) r_pc <= w_mis ? r_pc : redirect_addr;
        else if (ras_pop) r_pc <= w_empty ? w_next : w_top;
        else if (fetch_ready) r_pc <= w_next;
      end
    end
  assign fetch_valid   = r_fv;
  assign pc            = r_pc;
  assign misalign_err  = r_mis;
  assign ras_underflow = r_unf;
  assign ras_empty     = w_empty;
endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed vector table, corner sequences and a random run against a queue-based model.
module tb_pc_gen_unit;
  logic        clk = 1'b0;
  logic        rst_n, stall, trap_valid, redirect_valid, ras_push, ras_pop, halt_req, fetch_ready;
  logic [31:0] trap_vec, redirect_addr, ras_push_addr;
  logic        fv0, mis0, unf0, emp0, fv1, mis1, unf1, emp1, fv16, mis16, unf16, emp16;
  logic [31:0] pc0, pc1;
  logic [15:0] pc16;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  pc_gen_unit dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .trap_valid(trap_valid), .trap_vec(trap_vec),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .ras_push(ras_push),
    .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .halt_req(halt_req), .fetch_ready(fetch_ready),
    .fetch_valid(fv0), .pc(pc0), .misalign_err(mis0), .ras_underflow(unf0), .ras_empty(emp0));

  pc_gen_unit #(.C_EXT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .trap_valid(trap_valid), .trap_vec(trap_vec),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .ras_push(ras_push),
    .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .halt_req(halt_req), .fetch_ready(fetch_ready),
    .fetch_valid(fv1), .pc(pc1), .misalign_err(mis1), .ras_underflow(unf1), .ras_empty(emp1));

  pc_gen_unit #(.XLEN(16), .RESET_VEC(16'hFFF0)) dut16 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .trap_valid(trap_valid), .trap_vec(trap_vec[15:0]),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr[15:0]), .ras_push(ras_push),
    .ras_push_addr(ras_push_addr[15:0]), .ras_pop(ras_pop), .halt_req(halt_req), .fetch_ready(fetch_ready),
    .fetch_valid(fv16), .pc(pc16), .misalign_err(mis16), .ras_underflow(unf16), .ras_empty(emp16));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a booting/halted pair of flags and a bounded queue for the return stack.
  logic [31:0] m_pc = 32'h0, m_q[$];
  bit          m_boot = 1'b1, m_halt = 1'b0, m_mis = 1'b0, m_unf = 1'b0;

  task automatic model_step();
    if (!rst_n) begin
      m_pc = 32'h0; m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0; m_unf = 1'b0;
      m_q.delete();
    end else begin
      m_mis = 1'b0;
      m_unf = 1'b0;
      if (trap_valid) begin
        m_pc = trap_vec; m_boot = 1'b0; m_halt = 1'b0;
      end else if (m_boot) m_boot = 1'b0;
      else if (!m_halt && !stall) begin
        if (halt_req) m_halt = 1'b1;
        else if (redirect_valid) begin
          if (redirect_addr % 4 != 0) m_mis = 1'b1;
          else m_pc = redirect_addr;
        end else if (ras_pop) begin
          if (m_q.size() == 0) begin m_unf = 1'b1; m_pc = m_pc + 4; end
          else m_pc = m_q.pop_back();
        end else if (fetch_ready) m_pc = m_pc + 4;
      end
      if (!stall && ras_push) begin
        m_q.push_back(ras_push_addr);
        if (m_q.size() > 4) void'(m_q.pop_front());
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();

  always @(negedge clk) begin
    chk("model pc", pc0, m_pc);
    chk("model fetch_valid", fv0, !m_boot && !m_halt);
    chk("model misalign_err", mis0, m_mis);
    chk("model ras_underflow", unf0, m_unf);
    chk("model ras_empty", emp0, m_q.size() == 0);
  end

  typedef struct {
    logic [6:0]  f;
    logic [31:0] a, p, e_pc;
    logic [3:0]  e;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [6:0] f, input logic [31:0] a, p, e_pc, input logic [3:0] e);
    vec_t v;
    v.f = f; v.a = a; v.p = p; v.e_pc = e_pc; v.e = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    {stall, trap_valid, redirect_valid, ras_push, ras_pop, halt_req, fetch_ready} = v.f;
    trap_vec = v.a; redirect_addr = v.a; ras_push_addr = v.p;
  endtask

  vec_t idle;

  initial begin
    idle = mk(7'b0000001, 0, 0, 0, 4'b0);
    // f = {stall,trap,redir,push,pop,halt,fready}; e = {fetch_valid,misalign,underflow,empty}
    tbl.push_back(mk(7'b0000001, 32'h0,   32'h0,   32'h0,   4'b1001));
    tbl.push_back(mk(7'b0000001, 32'h0,   32'h0,   32'h4,   4'b1001));
    tbl.push_back(mk(7'b0000001, 32'h0,   32'h0,   32'h8,   4'b1001));
    tbl.push_back(mk(7'b0000001, 32'h0,   32'h0,   32'hC,   4'b1001));
    tbl.push_back(mk(7'b0000000, 32'h0,   32'h0,   32'hC,   4'b1001));
    tbl.push_back(mk(7'b1010001, 32'h100, 32'h0,   32'hC,   4'b1001));
    tbl.push_back(mk(7'b1010001, 32'h100, 32'h0,   32'hC,   4'b1001));
    tbl.push_back(mk(7'b0010001, 32'h100, 32'h0,   32'h100, 4'b1001));
    tbl.push_back(mk(7'b1100001, 32'h80,  32'h0,   32'h80,  4'b1001));
    tbl.push_back(mk(7'b0010001, 32'h102, 32'h0,   32'h80,  4'b1101));
    tbl.push_back(mk(7'b0000000, 32'h0,   32'h0,   32'h80,  4'b1001));
    tbl.push_back(mk(7'b0001000, 32'h0,   32'h10,  32'h80,  4'b1000));
    tbl.push_back(mk(7'b0001000, 32'h0,   32'h20,  32'h80,  4'b1000));
    tbl.push_back(mk(7'b0001000, 32'h0,   32'h30,  32'h80,  4'b1000));
    tbl.push_back(mk(7'b0001000, 32'h0,   32'h40,  32'h80,  4'b1000));
    tbl.push_back(mk(7'b0001000, 32'h0,   32'h50,  32'h80,  4'b1000));
    tbl.push_back(mk(7'b0000100, 32'h0,   32'h0,   32'h50,  4'b1000));
    tbl.push_back(mk(7'b0000100, 32'h0,   32'h0,   32'h40,  4'b1000));
    tbl.push_back(mk(7'b0000100, 32'h0,   32'h0,   32'h30,  4'b1000));
    tbl.push_back(mk(7'b0000100, 32'h0,   32'h0,   32'h20,  4'b1001));
    tbl.push_back(mk(7'b0000100, 32'h0,   32'h0,   32'h24,  4'b1011));
    tbl.push_back(mk(7'b0000000, 32'h0,   32'h0,   32'h24,  4'b1001));
    tbl.push_back(mk(7'b0001000, 32'h0,   32'h300, 32'h24,  4'b1000));
    tbl.push_back(mk(7'b0001100, 32'h0,   32'h400, 32'h300, 4'b1000));
    tbl.push_back(mk(7'b0000100, 32'h0,   32'h0,   32'h400, 4'b1001));
    tbl.push_back(mk(7'b0011000, 32'h500, 32'h600, 32'h500, 4'b1000));
    tbl.push_back(mk(7'b0000100, 32'h0,   32'h0,   32'h600, 4'b1001));
    tbl.push_back(mk(7'b0000011, 32'h0,   32'h0,   32'h600, 4'b0001));

    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset pc", pc0, 32'h0);
    chk("reset fetch_valid", fv0, 1'b0);
    chk("reset misalign_err", mis0, 1'b0);
    chk("reset ras_underflow", unf0, 1'b0);
    chk("reset ras_empty", emp0, 1'b1);
    chk("reset pc16", {16'h0, pc16}, 32'hFFF0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge clk); #1;
      chk($sformatf("row%0d pc", i), pc0, tbl[i].e_pc);
      chk($sformatf("row%0d fetch_valid", i), fv0, tbl[i].e[3]);
      chk($sformatf("row%0d misalign_err", i), mis0, tbl[i].e[2]);
      chk($sformatf("row%0d ras_underflow", i), unf0, tbl[i].e[1]);
      chk($sformatf("row%0d ras_empty", i), emp0, tbl[i].e[0]);
      @(negedge clk);
    end

    // Halted: redirects and pops must not move the PC for ten cycles.
    for (int i = 0; i < 10; i++) begin
      drive(mk(7'b0010101, 32'h700, 32'h0, 32'h0, 4'b0));
      @(posedge clk); #1;
      chk($sformatf("halt%0d pc", i), pc0, 32'h600);
      chk($sformatf("halt%0d fetch_valid", i), fv0, 1'b0);
      @(negedge clk);
    end
    drive(mk(7'b0100001, 32'h200, 32'h0, 32'h0, 4'b0));
    @(posedge clk); #1;
    chk("halt exit pc", pc0, 32'h200);
    chk("halt exit fetch_valid", fv0, 1'b1);
    @(negedge clk);

    drive(mk(7'b0010000, 32'h102, 32'h0, 32'h0, 4'b0));
    @(posedge clk); #1;
    chk("c_ext0 misaligned pc", pc0, 32'h200);
    chk("c_ext0 misalign_err", mis0, 1'b1);
    chk("c_ext1 halfword pc", pc1, 32'h102);
    chk("c_ext1 misalign_err", mis1, 1'b0);
    @(negedge clk);
    drive(mk(7'b0000000, 32'h0, 32'h0, 32'h0, 4'b0));
    @(posedge clk); #1;
    chk("misalign pulse end", mis0, 1'b0);
    @(negedge clk);

    // 16-bit instance: reset vector 0xFFF0 counts up and wraps to 0.
    #2 rst_n = 1'b0;
    #1;
    chk("async reset pc", pc0, 32'h0);
    chk("async reset fetch_valid", fv0, 1'b0);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("x16 boot pc", {16'h0, pc16}, 32'hFFF0);
    chk("x16 boot fetch_valid", fv16, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("x16 step%0d pc", k), {16'h0, pc16}, {16'h0, 16'(16'hFFF0 + 16'(4 * k))});
    end
    @(negedge clk);

    drive(mk(7'b0001000, 32'h0, 32'h40, 32'h0, 4'b0));
    @(negedge clk);
    drive(mk(7'b0000100, 32'h0, 32'h0, 32'h0, 4'b0));
    #3 rst_n = 1'b0;
    #1;
    chk("mid-pop reset pc", pc0, 32'h0);
    chk("mid-pop reset ras_empty", emp0, 1'b1);
    chk("mid-pop reset pc16", {16'h0, pc16}, 32'hFFF0);
    chk("mid-pop reset ras_empty16", emp16, 1'b1);
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;
    #1;
    chk("post reset fetch_valid", fv0, 1'b0);
    @(posedge clk); #1;
    chk("first fetch fetch_valid", fv0, 1'b1);
    chk("first fetch pc", pc0, 32'h0);
    @(negedge clk);

    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(7'b1100000, 32'h80, 32'h0, 32'h0, 4'b0));
    @(posedge clk); #1;
    chk("boot trap pc", pc0, 32'h80);
    chk("boot trap fetch_valid", fv0, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      stall          = ($urandom % 5) == 0;
      trap_valid     = ($urandom % 40) == 0;
      trap_vec       = $urandom & 32'hFFFF_FFFC;
      redirect_valid = ($urandom % 6) == 0;
      redirect_addr  = (($urandom % 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      ras_push       = ($urandom % 4) == 0;
      ras_push_addr  = $urandom;
      ras_pop        = ($urandom % 4) == 0;
      halt_req       = ($urandom % 50) == 0;
      fetch_ready    = ($urandom % 3) != 0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
